// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//   Shared constants, state encoding and index helpers for the convolution
//   sequencer. Imported by the interface, the top and anything else that needs
//   to agree on image/kernel geometry or index widths.
//
//   Contents:
//     IMG, K, OUT, TAPS      geometry of the image, kernel and output map
//     *_W                    counter and index widths derived from geometry
//     state_t                sequencer states, 3-bit encoding
//     tap_index()            ky*K+kx as a tap index
//     win_index()            oy*OUT+ox as an output index
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int IMG  = 6;
    localparam int K    = 3;
    localparam int OUT  = IMG - K + 1;
    localparam int TAPS = K * K;

    localparam int TAP_IDX_W = 4;
    localparam int OUT_IDX_W = 4;

    // rows_loaded must be able to hold IMG itself, hence IMG+1 values
    localparam int ROW_CNT_W = $clog2(IMG + 1);
    localparam int KPOS_W    = $clog2(K);
    localparam int OPOS_W    = $clog2(OUT);
    localparam int PIX_W     = $clog2(IMG);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [TAP_IDX_W-1:0] tap_index(
        input logic [KPOS_W-1:0] ky,
        input logic [KPOS_W-1:0] kx
    );
        return TAP_IDX_W'(ky) * TAP_IDX_W'(K) + TAP_IDX_W'(kx);
    endfunction

    function automatic logic [OUT_IDX_W-1:0] win_index(
        input logic [OPOS_W-1:0] oy,
        input logic [OPOS_W-1:0] ox
    );
        return OUT_IDX_W'(oy) * OUT_IDX_W'(OUT) + OUT_IDX_W'(ox);
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// ----------------------------------------------------------------------------
// conv_sequencer_if
//   Bundles the switch inputs, control inputs and MAC-facing outputs of the
//   convolution sequencer. clk and rst_n are kept outside as plain ports.
//
//   master modport (stimulus side) drives:
//     ena, row_strobe, row_data, start, clear
//   slave modport (sequencer side) drives:
//     tap_valid, tap_first, tap_last, tap_pix, tap_idx,
//     out_valid, out_idx, busy, done, rows_loaded
// ----------------------------------------------------------------------------
interface conv_sequencer_if;
    import conv_pkg::*;

    logic                 ena;
    logic                 row_strobe;
    logic [IMG-1:0]       row_data;
    logic                 start;
    logic                 clear;

    logic                 tap_valid;
    logic                 tap_first;
    logic                 tap_last;
    logic                 tap_pix;
    logic [TAP_IDX_W-1:0] tap_idx;
    logic                 out_valid;
    logic [OUT_IDX_W-1:0] out_idx;
    logic                 busy;
    logic                 done;
    logic [ROW_CNT_W-1:0] rows_loaded;

    modport master (
        output ena, row_strobe, row_data, start, clear,
        input  tap_valid, tap_first, tap_last, tap_pix, tap_idx,
        input  out_valid, out_idx, busy, done, rows_loaded
    );

    modport slave (
        input  ena, row_strobe, row_data, start, clear,
        output tap_valid, tap_first, tap_last, tap_pix, tap_idx,
        output out_valid, out_idx, busy, done, rows_loaded
    );

endinterface

// File: rtl/conv_sequencer_edge_sync.sv
// ----------------------------------------------------------------------------
// edge_sync
//   Two-flop synchronizer for a raw switch level followed by a one-deep
//   history register, producing a rising-edge pulse. All three flops freeze
//   while ena is low, so an edge seen just before a freeze is still reported
//   exactly once when ena returns.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     ena    in   clock enable for every flop in this block
//     din    in   raw asynchronous level
//     rise   out  high while the synchronized level is 1 and its previous
//                 sample was 0
// ----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic rise
);

    logic sync_meta;
    logic sync_now;
    logic sync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_now  <= 1'b0;
            sync_prev <= 1'b0;
        end else if (ena) begin
            sync_meta <= din;
            sync_now  <= sync_meta;
            sync_prev <= sync_now;
        end
    end

    assign rise = sync_now & ~sync_prev;

endmodule

// File: rtl/conv_sequencer.sv
// ----------------------------------------------------------------------------
// conv_sequencer
//   Control block in front of the convolution MAC datapath. Captures IMG
//   switch rows into an IMGxIMG binary image, then on a start edge walks every
//   KxK window in raster order, one tap per cycle. A result strobe for each
//   window is delayed MAC_LAT cycles behind the window's last tap so it lines
//   up with the accumulator output.
//
//   Parameters:
//     MAC_LAT    cycles from tap_last to the accumulator result being valid
//
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     bus        conv_sequencer_if.slave
//       ena          in   design enable; low freezes every register
//       row_strobe   in   raw level; each rising edge captures one row
//       row_data     in   row pixels, bit i is column i
//       start        in   raw level; a rising edge begins a run
//       clear        in   synchronous abort, discards the image
//       tap_valid    out  tap present this cycle
//       tap_first    out  first tap of a window (accumulator clear)
//       tap_last     out  last tap of a window
//       tap_pix      out  image[oy+ky][ox+kx]
//       tap_idx      out  ky*K+kx
//       out_valid    out  one-cycle result strobe
//       out_idx      out  oy*OUT+ox of the strobed result
//       busy         out  high in RUN and DRAIN
//       done         out  high in DONE
//       rows_loaded  out  rows captured so far, 0..IMG
// ----------------------------------------------------------------------------
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int MAC_LAT = 2
) (
    input logic            clk,
    input logic            rst_n,
    conv_sequencer_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic row_rise;
    logic start_rise;

    logic [ROW_CNT_W-1:0] rows_loaded;
    logic [IMG-1:0]       image [IMG];

    logic [KPOS_W-1:0] kx;
    logic [KPOS_W-1:0] ky;
    logic [OPOS_W-1:0] ox;
    logic [OPOS_W-1:0] oy;

    logic [MAC_LAT-1:0]   pipe_valid;
    logic [OUT_IDX_W-1:0] pipe_idx [MAC_LAT];

    logic [PIX_W-1:0]     pix_row;
    logic [PIX_W-1:0]     pix_col;
    logic [TAP_IDX_W-1:0] cur_tap;
    logic                 tap_end;
    logic                 win_last;
    logic                 drain_pending;
    logic                 row_write;
    logic                 start_go;

    logic tap_valid_i;
    logic tap_first_i;
    logic tap_last_i;
    logic tap_pix_i;

    edge_sync u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .din   (bus.row_strobe),
        .rise  (row_rise)
    );

    edge_sync u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .din   (bus.start),
        .rise  (start_rise)
    );

    // Window/tap geometry derived from the four raster counters.
    always_comb begin
        pix_row  = PIX_W'(oy) + PIX_W'(ky);
        pix_col  = PIX_W'(ox) + PIX_W'(kx);
        cur_tap  = tap_index(ky, kx);
        tap_end  = (cur_tap == TAP_IDX_W'(TAPS - 1));
        win_last = (ox == OPOS_W'(OUT - 1)) && (oy == OPOS_W'(OUT - 1));
    end

    // The run has fully drained once the stage now feeding out_valid is the
    // only one that could still hold a strobe; earlier stages must be empty.
    always_comb begin
        drain_pending = 1'b0;
        for (int i = 0; i < MAC_LAT - 1; i++) begin
            drain_pending = drain_pending | pipe_valid[i];
        end
    end

    // Row writes are only accepted while the image is still being filled, and
    // start only launches from READY or DONE; clear suppresses both.
    always_comb begin
        row_write = row_rise && !bus.clear && ((state == IDLE) || (state == LOAD));
        start_go  = start_rise && !bus.clear && ((state == READY) || (state == DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.ena) begin
            state <= state_nxt;
        end
    end

    // Next state and tap outputs. clear is applied last so it overrides any
    // transition chosen by the state case.
    always_comb begin
        state_nxt   = state;
        tap_valid_i = 1'b0;
        tap_first_i = 1'b0;
        tap_last_i  = 1'b0;
        tap_pix_i   = 1'b0;

        case (state)
            IDLE: begin
                if (row_rise) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (row_rise && (rows_loaded == ROW_CNT_W'(IMG - 1))) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (start_rise) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                tap_valid_i = 1'b1;
                tap_first_i = (kx == '0) && (ky == '0);
                tap_last_i  = tap_end;
                tap_pix_i   = image[pix_row][pix_col];
                if (tap_end && win_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_pending) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start_rise) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (bus.clear) begin
            state_nxt = IDLE;
        end
    end

    // Image capture. rows_loaded doubles as the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_loaded <= '0;
            for (int r = 0; r < IMG; r++) begin
                image[r] <= '0;
            end
        end else if (bus.ena) begin
            if (bus.clear) begin
                rows_loaded <= '0;
                for (int r = 0; r < IMG; r++) begin
                    image[r] <= '0;
                end
            end else if (row_write) begin
                image[rows_loaded] <= bus.row_data;
                rows_loaded        <= rows_loaded + ROW_CNT_W'(1);
            end
        end
    end

    // Raster counters: kx fastest, then ky, then ox, then oy. The final tap
    // wraps everything back to zero so a replay from DONE starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (bus.ena) begin
            if (bus.clear || start_go) begin
                kx <= '0;
                ky <= '0;
                ox <= '0;
                oy <= '0;
            end else if (state == RUN) begin
                if (kx == KPOS_W'(K - 1)) begin
                    kx <= '0;
                    if (ky == KPOS_W'(K - 1)) begin
                        ky <= '0;
                        if (ox == OPOS_W'(OUT - 1)) begin
                            ox <= '0;
                            if (oy == OPOS_W'(OUT - 1)) begin
                                oy <= '0;
                            end else begin
                                oy <= oy + OPOS_W'(1);
                            end
                        end else begin
                            ox <= ox + OPOS_W'(1);
                        end
                    end else begin
                        ky <= ky + KPOS_W'(1);
                    end
                end else begin
                    kx <= kx + KPOS_W'(1);
                end
            end
        end
    end

    // Result-strobe delay line. The window index is captured alongside
    // tap_last while oy/ox still describe the window that is finishing.
    // clear flushes every stage so no strobe escapes an aborted run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else if (bus.ena) begin
            if (bus.clear) begin
                pipe_valid <= '0;
                for (int i = 0; i < MAC_LAT; i++) begin
                    pipe_idx[i] <= '0;
                end
            end else begin
                pipe_valid[0] <= tap_last_i;
                pipe_idx[0]   <= win_index(oy, ox);
                for (int i = 1; i < MAC_LAT; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                    pipe_idx[i]   <= pipe_idx[i-1];
                end
            end
        end
    end

    assign bus.tap_valid   = tap_valid_i;
    assign bus.tap_first   = tap_first_i;
    assign bus.tap_last    = tap_last_i;
    assign bus.tap_pix     = tap_pix_i;
    assign bus.tap_idx     = cur_tap;
    assign bus.out_valid   = pipe_valid[MAC_LAT-1];
    assign bus.out_idx     = pipe_idx[MAC_LAT-1];
    assign bus.busy        = (state == RUN) || (state == DRAIN);
    assign bus.done        = (state == DONE);
    assign bus.rows_loaded = rows_loaded;

endmodule

// File: tb/tb_conv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_conv_sequencer
//   Self-checking bench for conv_sequencer. Row loads are driven from a table
//   of {row value, strobe hold, model slot, expected rows_loaded, expected
//   done}; runs are checked cycle by cycle against a window/tap model built
//   from the bench's own copy of the image.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_conv_sequencer;

    localparam int N_OUT    = 4;
    localparam int N_TAP    = 9;
    localparam int RUN_LEN  = 144;
    localparam int LAT      = 2;
    localparam int LAST_CYC = RUN_LEN + LAT;

    typedef struct {
        logic [5:0] row;
        int         hold;
        int         slot;
        int         exp_rows;
        logic       exp_done;
    } load_vec_t;

    logic clk;
    logic rst_n;

    conv_sequencer_if cs_if ();

    conv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cs_if)
    );

    int         pass_cnt;
    int         total_cnt;
    logic [5:0] img_model [6];
    load_vec_t  tab [20];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input load_vec_t v);
        cs_if.row_data   = v.row;
        cs_if.row_strobe = 1'b1;
        repeat (v.hold) tick();
        cs_if.row_strobe = 1'b0;
        repeat (4) tick();
        if (v.slot >= 0) begin
            img_model[v.slot] = v.row;
        end
        check_output("rows_loaded", cs_if.rows_loaded, v.exp_rows);
        check_output("busy_done", {cs_if.busy, cs_if.done}, {1'b0, v.exp_done});
    endtask

    task automatic check_cycle(input int c);
        int         w, t, oy, ox, ky, kx;
        logic       pix;
        logic [7:0] want_tap;
        logic [7:0] got_tap;
        int         want_ov;
        int         want_oi;

        if (c < RUN_LEN) begin
            w  = c / N_TAP;
            t  = c % N_TAP;
            oy = w / N_OUT;
            ox = w % N_OUT;
            ky = t / 3;
            kx = t % 3;
            pix = img_model[oy + ky][ox + kx];
            want_tap = {1'b1, (t == 0), (t == N_TAP - 1), pix, 4'(t)};
            got_tap  = {cs_if.tap_valid, cs_if.tap_first, cs_if.tap_last,
                        cs_if.tap_pix, cs_if.tap_idx};
            check_output($sformatf("tap@%0d", c), got_tap, want_tap);
        end else begin
            check_output($sformatf("tap_valid@%0d", c), cs_if.tap_valid, 0);
        end

        want_ov = 0;
        want_oi = 0;
        if (c >= N_TAP - 1 + LAT && ((c - (N_TAP - 1 + LAT)) % N_TAP) == 0
            && ((c - (N_TAP - 1 + LAT)) / N_TAP) < N_OUT * N_OUT) begin
            want_ov = 1;
            want_oi = (c - (N_TAP - 1 + LAT)) / N_TAP;
        end
        check_output($sformatf("out@%0d", c),
                     {cs_if.out_valid, (cs_if.out_valid ? cs_if.out_idx : 4'd0)},
                     {want_ov[0], 4'(want_oi)});

        check_output($sformatf("busy_done@%0d", c), {cs_if.busy, cs_if.done},
                     {(c < LAST_CYC) ? 1'b1 : 1'b0, (c == LAST_CYC) ? 1'b1 : 1'b0});
    endtask

    task automatic run_check(input int pause_at, input int clear_at, input bit diag);
        int         waited;
        int         ov_cnt;
        logic [8:0] mask;

        mask   = '0;
        waited = 0;
        cs_if.start = 1'b1;
        do begin
            tick();
            waited++;
        end while (!cs_if.tap_valid && waited < 10);
        cs_if.start = 1'b0;
        check_output("start_latency", waited, 3);
        check_output("run_started", cs_if.tap_valid, 1);
        if (!cs_if.tap_valid) begin
            return;
        end

        for (int c = 0; c <= LAST_CYC; c++) begin
            if (c > 0) begin
                tick();
            end
            check_cycle(c);
            if (diag && c < RUN_LEN && (c / N_TAP) == 5 && cs_if.tap_pix) begin
                mask[cs_if.tap_idx] = 1'b1;
            end
            if (c == pause_at) begin
                cs_if.ena = 1'b0;
                repeat (10) begin
                    tick();
                    check_cycle(c);
                end
                cs_if.ena = 1'b1;
            end
            if (c == clear_at) begin
                cs_if.clear = 1'b1;
                tick();
                cs_if.clear = 1'b0;
                check_output("clear_state",
                             {cs_if.busy, cs_if.done, cs_if.tap_valid, cs_if.tap_idx}, 0);
                check_output("clear_rows", cs_if.rows_loaded, 0);
                ov_cnt = 0;
                repeat (20) begin
                    tick();
                    if (cs_if.out_valid) ov_cnt++;
                end
                check_output("out_after_clear", ov_cnt, 0);
                for (int r = 0; r < 6; r++) img_model[r] = '0;
                return;
            end
        end

        if (diag) begin
            check_output("diag_win5_mask", mask, 9'h111);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int r = 0; r < 6; r++) img_model[r] = '0;

        // Plan image, then a row edge in READY that must be ignored.
        tab[0]  = '{6'h3F,  4,  0, 1, 1'b0};
        tab[1]  = '{6'h00,  4,  1, 2, 1'b0};
        tab[2]  = '{6'h15,  4,  2, 3, 1'b0};
        tab[3]  = '{6'h2A,  4,  3, 4, 1'b0};
        tab[4]  = '{6'h0F,  4,  4, 5, 1'b0};
        tab[5]  = '{6'h30,  4,  5, 6, 1'b0};
        tab[6]  = '{6'h01,  4, -1, 6, 1'b0};
        // Row edge while DONE: ignored, done stays high.
        tab[7]  = '{6'h3F,  4, -1, 6, 1'b1};
        // All-ones image.
        tab[8]  = '{6'h3F,  4,  0, 1, 1'b0};
        tab[9]  = '{6'h3F,  4,  1, 2, 1'b0};
        tab[10] = '{6'h3F,  4,  2, 3, 1'b0};
        tab[11] = '{6'h3F,  4,  3, 4, 1'b0};
        tab[12] = '{6'h3F,  4,  4, 5, 1'b0};
        tab[13] = '{6'h3F,  4,  5, 6, 1'b0};
        // Identity diagonal; the second row strobe is held for 20 cycles.
        tab[14] = '{6'h01,  4,  0, 1, 1'b0};
        tab[15] = '{6'h02, 20,  1, 2, 1'b0};
        tab[16] = '{6'h04,  4,  2, 3, 1'b0};
        tab[17] = '{6'h08,  4,  3, 4, 1'b0};
        tab[18] = '{6'h10,  4,  4, 5, 1'b0};
        tab[19] = '{6'h20,  4,  5, 6, 1'b0};

        rst_n            = 1'b0;
        cs_if.ena        = 1'b1;
        cs_if.row_strobe = 1'b0;
        cs_if.row_data   = '0;
        cs_if.start      = 1'b0;
        cs_if.clear      = 1'b0;

        repeat (3) tick();
        check_output("reset_rows", cs_if.rows_loaded, 0);
        check_output("reset_tap",
                     {cs_if.tap_valid, cs_if.tap_first, cs_if.tap_last,
                      cs_if.tap_pix, cs_if.tap_idx}, 0);
        check_output("reset_out", {cs_if.out_valid, cs_if.out_idx}, 0);
        check_output("reset_busy_done", {cs_if.busy, cs_if.done}, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] loading plan image");
        for (int i = 0; i <= 6; i++) apply_stimulus(tab[i]);

        $display("[TB] run with ena pause");
        run_check(50, -1, 1'b0);

        $display("[TB] row edge in DONE, then replay");
        apply_stimulus(tab[7]);
        run_check(-1, -1, 1'b0);

        $display("[TB] clear from DONE, load all-ones");
        cs_if.clear = 1'b1;
        tick();
        cs_if.clear = 1'b0;
        for (int r = 0; r < 6; r++) img_model[r] = '0;
        check_output("clear_done_rows", cs_if.rows_loaded, 0);
        check_output("clear_done_state", {cs_if.busy, cs_if.done}, 0);
        for (int i = 8; i <= 13; i++) apply_stimulus(tab[i]);
        run_check(-1, -1, 1'b0);

        $display("[TB] replay aborted by clear on a window's last tap");
        run_check(-1, 53, 1'b0);

        $display("[TB] diagonal image after clear");
        for (int i = 14; i <= 19; i++) apply_stimulus(tab[i]);
        run_check(-1, -1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
